// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues memory reads, registers the
// returned instruction, and stops on HALT, misaligned next PC or memory timeout.
module pc_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] next_pc,
  input  logic        halt,
  input  logic        mem_done,
  input  logic        mem_stall,
  input  logic [15:0] instr_in,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        mem_rd,
  output logic [15:0] instr_out,
  output logic        instr_valid,
  output logic        halted,
  output logic        err
);
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam int            CW    = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WLAST = CW'(MAX_WAIT - 1);

  logic [1:0]    state;
  logic [CW-1:0] wcnt;
  logic          ack;

  // A completion only counts when memory is not simultaneously stalling.
  assign ack         = mem_done & ~mem_stall;
  assign pc_plus2    = pc + 16'd2;
  assign instr_valid = (state == S_ISSUE);
  assign mem_rd      = ~rst & ((state == S_FETCH) | (state == S_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      instr_out <= 16'h0000;
      halted    <= 1'b0;
      err       <= 1'b0;
      wcnt      <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          wcnt <= '0;
          if (ack) begin
            instr_out <= instr_in;
            state     <= S_ISSUE;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // mem_done on the last allowed cycle beats the timeout
          if (ack) begin
            instr_out <= instr_in;
            state     <= S_ISSUE;
          end else if (wcnt == WLAST) begin
            err    <= 1'b1;
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_ISSUE: begin
          if (halt) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else if (next_pc[0]) begin
            err    <= 1'b1;
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            pc    <= next_pc;
            wcnt  <= '0;
            state <= S_FETCH;
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: hand-computed vectors covering reset,
// zero-latency fetch, stalls, halt, misalignment, timeout and mid-flight reset.
module tb_pc_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] next_pc;
  logic        halt;
  logic        mem_done;
  logic        mem_stall;
  logic [15:0] instr_in;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        mem_rd;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        halted;
  logic        err;

  int checks = 0;
  int failures = 0;

  pc_fetch_ctrl #(.RESET_PC(16'h0000), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst), .next_pc(next_pc), .halt(halt),
    .mem_done(mem_done), .mem_stall(mem_stall), .instr_in(instr_in),
    .pc(pc), .pc_plus2(pc_plus2), .mem_rd(mem_rd), .instr_out(instr_out),
    .instr_valid(instr_valid), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_mem_rd", {15'd0, mem_rd}, 16'd0);
    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_instr", instr_out, 16'h0000);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_mem_rd", {15'd0, mem_rd}, 16'd1);
  endtask

  initial begin
    rst = 1'b0; next_pc = 16'h0; halt = 1'b0; mem_done = 1'b0;
    mem_stall = 1'b0; instr_in = 16'h0;
    #2;
    do_reset();
    chk("rst_pc_plus2", pc_plus2, 16'h0002);

    // Zero-latency memory: pc 0,2,4,6, one valid every second cycle
    for (int i = 0; i < 4; i++) begin
      chk("zl_pc", pc, 16'(2 * i));
      chk("zl_fetch_rd", {15'd0, mem_rd}, 16'd1);
      chk("zl_fetch_valid", {15'd0, instr_valid}, 16'd0);
      mem_done = 1'b1; instr_in = 16'h1000 + 16'(i); next_pc = 16'(2 * i + 2);
      step();
      chk("zl_issue_valid", {15'd0, instr_valid}, 16'd1);
      chk("zl_issue_rd", {15'd0, mem_rd}, 16'd0);
      chk("zl_instr", instr_out, 16'h1000 + 16'(i));
      step();
    end

    // Stall three cycles then deliver A5A5 at pc 8
    chk("st_pc_start", pc, 16'h0008);
    mem_done = 1'b0; mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_pc", pc, 16'h0008);
      chk("st_rd", {15'd0, mem_rd}, 16'd1);
      chk("st_valid", {15'd0, instr_valid}, 16'd0);
    end
    mem_stall = 1'b0; mem_done = 1'b1; instr_in = 16'hA5A5; next_pc = 16'h0010;
    step();
    chk("st_valid_pulse", {15'd0, instr_valid}, 16'd1);
    chk("st_instr", instr_out, 16'hA5A5);
    chk("st_pc_issue", pc, 16'h0008);
    mem_done = 1'b0;
    step();
    chk("st_valid_drop", {15'd0, instr_valid}, 16'd0);
    chk("st_pc_next", pc, 16'h0010);

    // Halt at 0x0010, with misaligned next_pc present: halt wins, no err
    mem_done = 1'b1; instr_in = 16'hF000;
    step();
    halt = 1'b1; next_pc = 16'h0023;
    step();
    halt = 1'b0;
    chk("h_halted", {15'd0, halted}, 16'd1);
    chk("h_err", {15'd0, err}, 16'd0);
    chk("h_pc", pc, 16'h0010);
    for (int i = 0; i < 4; i++) begin
      mem_done = i[0]; mem_stall = i[1];
      step();
      chk("h_rd", {15'd0, mem_rd}, 16'd0);
      chk("h_pc_hold", pc, 16'h0010);
      chk("h_instr_hold", instr_out, 16'hF000);
      chk("h_valid", {15'd0, instr_valid}, 16'd0);
    end
    mem_stall = 1'b0;
    do_reset();

    // Misaligned next_pc: err + halted, pc unchanged
    mem_done = 1'b1; instr_in = 16'h2222;
    step();
    next_pc = 16'h0023;
    step();
    chk("ma_err", {15'd0, err}, 16'd1);
    chk("ma_halted", {15'd0, halted}, 16'd1);
    chk("ma_pc", pc, 16'h0000);
    chk("ma_rd", {15'd0, mem_rd}, 16'd0);
    do_reset();

    // Timeout: no mem_done, err rises after the 8th WAIT cycle
    mem_done = 1'b0;
    step();
    for (int i = 0; i < 7; i++) begin
      step();
      chk("to_err_early", {15'd0, err}, 16'd0);
      chk("to_rd", {15'd0, mem_rd}, 16'd1);
    end
    step();
    chk("to_err", {15'd0, err}, 16'd1);
    chk("to_halted", {15'd0, halted}, 16'd1);
    chk("to_rd_off", {15'd0, mem_rd}, 16'd0);
    do_reset();

    // Same run, mem_done in the 8th WAIT cycle wins
    mem_done = 1'b0;
    step();
    for (int i = 0; i < 7; i++) step();
    mem_done = 1'b1; instr_in = 16'h5A5A;
    step();
    chk("tw_err", {15'd0, err}, 16'd0);
    chk("tw_valid", {15'd0, instr_valid}, 16'd1);
    chk("tw_instr", instr_out, 16'h5A5A);
    mem_done = 1'b0; next_pc = 16'h0002;
    step();
    chk("tw_pc", pc, 16'h0002);

    // Reset mid-WAIT abandons the request
    step();
    step();
    chk("rw_in_wait", {15'd0, mem_rd}, 16'd1);
    do_reset();
    chk("rw_restart_pc", pc, 16'h0000);
    chk("rw_instr_clear", instr_out, 16'h0000);
    mem_done = 1'b1; instr_in = 16'h1234;
    step();
    chk("rw_valid", {15'd0, instr_valid}, 16'd1);
    chk("rw_instr", instr_out, 16'h1234);

    // pc_plus2 wrap at 0xFFFE
    mem_done = 1'b0; next_pc = 16'hFFFE;
    step();
    chk("wrap_pc", pc, 16'hFFFE);
    chk("wrap_plus2", pc_plus2, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
